// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing controller: Moore FSM that decodes IR_O
// and drives datapath strobes/mux selects, with condition flags latched from the ALU.
module multicycle_controller #(
   parameter logic [3:0] ALU_ADD = 4'b0100,
   parameter logic [3:0] CMP_OP  = 4'b1010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR_O,
   input  logic        Z,
   input  logic        C,
   input  logic        N,
   input  logic        V,
   input  logic        lt,
   input  logic        gt,
   output logic        Mem_read,
   output logic        Mem_write,
   output logic        reg_write,
   output logic        PC_write,
   output logic        Jump,
   output logic        ldPCreg,
   output logic        IRwrite,
   output logic        IoD,
   output logic        PCreg,
   output logic        WAddr,
   output logic        DT_store,
   output logic        ALUsrcA,
   output logic        PCsrc,
   output logic [1:0]  ALUsrcB,
   output logic [1:0]  writeMux,
   output logic [3:0]  ALUoperation,
   output logic        instr_done
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      DP_EXEC  = 4'd2,
      DP_WB    = 4'd3,
      MEM_ADDR = 4'd4,
      MEM_RD   = 4'd5,
      MEM_WB   = 4'd6,
      MEM_ST   = 4'd7,
      BL_LINK  = 4'd8,
      BR       = 4'd9
   } state_t;

   state_t state, next_state;
   logic   z_f, lt_f, gt_f;
   logic   cond_pass;

   logic [3:0] cond;
   logic [1:0] itype;
   logic       imm;
   logic [3:0] opcode;
   logic       s_l;

   assign cond   = IR_O[31:28];
   assign itype  = IR_O[27:26];
   assign imm    = IR_O[25];
   assign opcode = IR_O[24:21];
   assign s_l    = IR_O[20];

   // Remaining fields belong to the datapath; C/N/V are not consulted by any condition.
   logic unused_inputs;
   assign unused_inputs = ^{IR_O[19:0], C, N, V};

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         z_f   <= 1'b0;
         lt_f  <= 1'b0;
         gt_f  <= 1'b0;
      end else begin
         state <= next_state;
         if (state == DP_EXEC && s_l) begin
            z_f  <= Z;
            lt_f <= lt;
            gt_f <= gt;
         end
      end
   end

   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'b0000: cond_pass = z_f;
         4'b0001: cond_pass = ~z_f;
         4'b0010: cond_pass = gt_f;
         4'b0011: cond_pass = lt_f;
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   always_comb begin
      next_state   = FETCH;
      Mem_read     = 1'b0;
      Mem_write    = 1'b0;
      reg_write    = 1'b0;
      PC_write     = 1'b0;
      Jump         = 1'b0;
      ldPCreg      = 1'b0;
      IRwrite      = 1'b0;
      IoD          = 1'b0;
      PCreg        = 1'b0;
      WAddr        = 1'b0;
      DT_store     = 1'b0;
      ALUsrcA      = 1'b0;
      PCsrc        = 1'b0;
      ALUsrcB      = '0;
      writeMux     = '0;
      ALUoperation = '0;
      instr_done   = 1'b0;

      case (state)
         FETCH: begin
            Mem_read     = 1'b1;
            IRwrite      = 1'b1;
            ldPCreg      = 1'b1;
            PC_write     = 1'b1;
            ALUsrcB      = 2'b01;
            ALUoperation = ALU_ADD;
            next_state   = DECODE;
         end
         DECODE: begin
            // Branch target is precomputed here so BR only has to select ALU_out.
            PCreg        = 1'b1;
            ALUsrcB      = 2'b11;
            ALUoperation = ALU_ADD;
            if (!cond_pass) begin
               instr_done = 1'b1;
               next_state = FETCH;
            end else begin
               case (itype)
                  2'b00:   next_state = DP_EXEC;
                  2'b01:   next_state = MEM_ADDR;
                  2'b10:   next_state = BR;
                  default: next_state = BL_LINK;
               endcase
            end
         end
         DP_EXEC: begin
            ALUsrcA      = 1'b1;
            ALUsrcB      = imm ? 2'b10 : 2'b00;
            ALUoperation = opcode;
            if (opcode == CMP_OP) begin
               instr_done = 1'b1;
               next_state = FETCH;
            end else begin
               next_state = DP_WB;
            end
         end
         DP_WB: begin
            reg_write  = 1'b1;
            writeMux   = 2'b01;
            instr_done = 1'b1;
            next_state = FETCH;
         end
         MEM_ADDR: begin
            ALUsrcA      = 1'b1;
            ALUsrcB      = 2'b10;
            ALUoperation = ALU_ADD;
            next_state   = s_l ? MEM_RD : MEM_ST;
         end
         MEM_RD: begin
            IoD        = 1'b1;
            Mem_read   = 1'b1;
            next_state = MEM_WB;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            writeMux   = 2'b00;
            instr_done = 1'b1;
            next_state = FETCH;
         end
         MEM_ST: begin
            IoD        = 1'b1;
            Mem_write  = 1'b1;
            DT_store   = 1'b1;
            instr_done = 1'b1;
            next_state = FETCH;
         end
         BL_LINK: begin
            reg_write  = 1'b1;
            WAddr      = 1'b1;
            writeMux   = 2'b10;
            next_state = BR;
         end
         BR: begin
            Jump       = 1'b1;
            PCsrc      = 1'b1;
            instr_done = 1'b1;
            next_state = FETCH;
         end
         default: next_state = FETCH;
      endcase

      // Outputs are gated by reset so no write strobe escapes mid-instruction.
      if (reset) begin
         Mem_read     = 1'b0;
         Mem_write    = 1'b0;
         reg_write    = 1'b0;
         PC_write     = 1'b0;
         Jump         = 1'b0;
         ldPCreg      = 1'b0;
         IRwrite      = 1'b0;
         IoD          = 1'b0;
         PCreg        = 1'b0;
         WAddr        = 1'b0;
         DT_store     = 1'b0;
         ALUsrcA      = 1'b0;
         PCsrc        = 1'b0;
         ALUsrcB      = '0;
         writeMux     = '0;
         ALUoperation = '0;
         instr_done   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output vectors
// are queued from an instruction-level model and compared against the DUT.
module tb_multicycle_controller;

   logic        clk;
   logic        reset;
   logic [31:0] IR_O;
   logic        Z, C, N, V, lt, gt;
   logic        Mem_read, Mem_write, reg_write, PC_write, Jump, ldPCreg, IRwrite;
   logic        IoD, PCreg, WAddr, DT_store, ALUsrcA, PCsrc;
   logic [1:0]  ALUsrcB, writeMux;
   logic [3:0]  ALUoperation;
   logic        instr_done;

   typedef struct packed {
      logic       mem_read, mem_write, reg_write, pc_write, jump, ldpcreg, irwrite;
      logic       iod, pcreg, waddr, dt_store, alusrca, pcsrc;
      logic [1:0] alusrcb, writemux;
      logic [3:0] aluop;
      logic       done;
   } ov_t;

   ov_t dut_ov;
   assign dut_ov = {Mem_read, Mem_write, reg_write, PC_write, Jump, ldPCreg, IRwrite,
                    IoD, PCreg, WAddr, DT_store, ALUsrcA, PCsrc,
                    ALUsrcB, writeMux, ALUoperation, instr_done};

   ov_t  exp_q[$];
   logic mz, mlt, mgt;
   int   tests, fails;

   multicycle_controller #(.ALU_ADD(4'b0100), .CMP_OP(4'b1010)) dut (
      .clk(clk), .reset(reset), .IR_O(IR_O),
      .Z(Z), .C(C), .N(N), .V(V), .lt(lt), .gt(gt),
      .Mem_read(Mem_read), .Mem_write(Mem_write), .reg_write(reg_write),
      .PC_write(PC_write), .Jump(Jump), .ldPCreg(ldPCreg), .IRwrite(IRwrite),
      .IoD(IoD), .PCreg(PCreg), .WAddr(WAddr), .DT_store(DT_store),
      .ALUsrcA(ALUsrcA), .PCsrc(PCsrc), .ALUsrcB(ALUsrcB), .writeMux(writeMux),
      .ALUoperation(ALUoperation), .instr_done(instr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Instruction-level model: pushes one expected vector per cycle, returns latency.
   task automatic push_instr(input logic [31:0] ir, input logic zi, input logic lti,
                             input logic gti, output int lat);
      ov_t e;
      logic pass;
      e = '0;
      e.mem_read = 1'b1; e.irwrite = 1'b1; e.ldpcreg = 1'b1; e.pc_write = 1'b1;
      e.alusrcb = 2'b01; e.aluop = 4'b0100;
      exp_q.push_back(e);

      case (ir[31:28])
         4'b0000: pass = mz;
         4'b0001: pass = !mz;
         4'b0010: pass = mgt;
         4'b0011: pass = mlt;
         4'b1110: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      e = '0;
      e.pcreg = 1'b1; e.alusrcb = 2'b11; e.aluop = 4'b0100;
      if (!pass) begin
         e.done = 1'b1;
         exp_q.push_back(e);
         lat = 2;
         return;
      end
      exp_q.push_back(e);

      case (ir[27:26])
         2'b00: begin
            e = '0;
            e.alusrca = 1'b1;
            e.alusrcb = ir[25] ? 2'b10 : 2'b00;
            e.aluop   = ir[24:21];
            if (ir[20]) begin mz = zi; mlt = lti; mgt = gti; end
            if (ir[24:21] == 4'b1010) begin
               e.done = 1'b1;
               exp_q.push_back(e);
               lat = 3;
            end else begin
               exp_q.push_back(e);
               e = '0; e.reg_write = 1'b1; e.writemux = 2'b01; e.done = 1'b1;
               exp_q.push_back(e);
               lat = 4;
            end
         end
         2'b01: begin
            e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = 4'b0100;
            exp_q.push_back(e);
            if (ir[20]) begin
               e = '0; e.iod = 1'b1; e.mem_read = 1'b1;
               exp_q.push_back(e);
               e = '0; e.reg_write = 1'b1; e.writemux = 2'b00; e.done = 1'b1;
               exp_q.push_back(e);
               lat = 5;
            end else begin
               e = '0; e.iod = 1'b1; e.mem_write = 1'b1; e.dt_store = 1'b1; e.done = 1'b1;
               exp_q.push_back(e);
               lat = 4;
            end
         end
         2'b10: begin
            e = '0; e.jump = 1'b1; e.pcsrc = 1'b1; e.done = 1'b1;
            exp_q.push_back(e);
            lat = 3;
         end
         default: begin
            e = '0; e.reg_write = 1'b1; e.waddr = 1'b1; e.writemux = 2'b10;
            exp_q.push_back(e);
            e = '0; e.jump = 1'b1; e.pcsrc = 1'b1; e.done = 1'b1;
            exp_q.push_back(e);
            lat = 4;
         end
      endcase
   endtask

   // Entered just after a falling edge with the DUT in FETCH; leaves it the same way.
   // abort_at > 0 asserts reset during that cycle of the instruction.
   task automatic run_instr(input string name, input logic [31:0] ir, input logic zi,
                            input logic lti, input logic gti, input int abort_at);
      ov_t e;
      int  lat, n, done_at, pulses;
      IR_O = ir; Z = zi; lt = lti; gt = gti;
      push_instr(ir, zi, lti, gti, lat);
      #1;
      n = 0; done_at = 0; pulses = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n++;
         if (n == abort_at) begin
            reset = 1'b1;
            #1;
            check({name, "/reset_outputs"}, 32'(dut_ov), 32'd0);
            exp_q.delete();
            mz = 1'b0; mlt = 1'b0; mgt = 1'b0;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            #1;
            return;
         end
         check($sformatf("%s/cycle%0d", name, n), 32'(dut_ov), 32'(e));
         if (instr_done) begin
            pulses++;
            if (done_at == 0) done_at = n;
         end
         @(posedge clk);
         @(negedge clk);
         #1;
      end
      check({name, "/latency"}, done_at, lat);
      check({name, "/done_pulses"}, pulses, 1);
   endtask

   initial begin
      tests = 0; fails = 0;
      mz = 1'b0; mlt = 1'b0; mgt = 1'b0;
      reset = 1'b1; IR_O = 32'hE0800000;
      Z = 1'b1; C = 1'b0; N = 1'b0; V = 1'b0; lt = 1'b1; gt = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("reset_outputs", 32'(dut_ov), 32'd0);
      reset = 1'b0;

      run_instr("add_reg",   32'hE0800000, 1'b0, 1'b0, 1'b0, 0);
      run_instr("add_imm",   32'hE2800001, 1'b0, 1'b0, 1'b0, 0);
      run_instr("cmp_z1",    32'hE1500000, 1'b1, 1'b0, 1'b0, 0);
      run_instr("beq_taken", 32'h08000005, 1'b0, 1'b0, 1'b0, 0);
      run_instr("bne_skip",  32'h18000005, 1'b0, 1'b0, 1'b0, 0);
      run_instr("cmp_nos",   32'hE1400000, 1'b0, 1'b1, 1'b1, 0);
      run_instr("beq_kept",  32'h08000005, 1'b0, 1'b0, 1'b0, 0);
      run_instr("load",      32'hE4100004, 1'b0, 1'b0, 1'b0, 0);
      run_instr("store",     32'hE4000004, 1'b0, 1'b0, 1'b0, 0);
      run_instr("bl",        32'hEC000010, 1'b0, 1'b0, 1'b0, 0);
      run_instr("cmp_gt",    32'hE1500000, 1'b0, 1'b0, 1'b1, 0);
      run_instr("bgt_taken", 32'h28000001, 1'b0, 1'b0, 1'b0, 0);
      run_instr("blt_skip",  32'h38000001, 1'b0, 1'b0, 1'b0, 0);
      run_instr("cond5_skip",32'h58000001, 1'b0, 1'b0, 1'b0, 0);
      run_instr("cmp_z1b",   32'hE1500000, 1'b1, 1'b0, 1'b0, 0);
      run_instr("load_rst",  32'hE4100004, 1'b0, 1'b0, 1'b0, 4);
      run_instr("beq_after_rst", 32'h08000005, 1'b1, 1'b0, 1'b0, 0);
      run_instr("add_final", 32'hE0800000, 1'b0, 1'b0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALU_ADD, default 4'b0100: ALUoperation code for addition.
REQ-002 Parameter CMP_OP, default 4'b1010: data-processing opcode that updates flags without register writeback.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 IR_O  input  32  instruction register contents.
REQ-006 Z, C, N, V  input  1 each  combinational ALU flags.
REQ-007 lt, gt  input  1 each  combinational compare results.
REQ-008 Mem_read, Mem_write, reg_write, PC_write, Jump, ldPCreg, IRwrite  output  1 each  datapath strobes.
REQ-009 IoD, PCreg, WAddr, DT_store, ALUsrcA, PCsrc  output  1 each  mux selects.
REQ-010 ALUsrcB, writeMux  output  2 each; ALUoperation  output  4.
REQ-011 instr_done  output  1  one-cycle pulse in the final state of each instruction, including skipped ones.

Function
REQ-012 Encoding: IR[31:28] cond; IR[27:26] type (00 DP, 01 transfer, 10 B, 11 BL); IR[25] immediate; IR[24:21] DP opcode; IR[20] S (DP) or L (transfer); IR[25:0] branch offset.
REQ-013 Conditions: 0000 EQ (Z_f=1); 0001 NE (Z_f=0); 0010 GT (gt_f=1); 0011 LT (lt_f=1); 1110 AL; all other codes evaluate to fail.
REQ-014 Z_f, lt_f, gt_f are internal flag registers, loaded from Z, lt, gt at the end of DP_EXEC only when IR[20]=1.
REQ-015 Mux encodings: IoD 0=PC, 1=ALU_out; ALUsrcA 0=PC mux, 1=A; PCreg 0=PC, 1=saved PC; ALUsrcB 00=B, 01=const 1, 10=OP2Reg, 11=sext26; PCsrc 0=ALU result, 1=ALU_out; writeMux 00=MDR, 01=ALU_out, 10=PC; WAddr 0=Rd, 1=R15.
REQ-016 Outputs are Moore decodes of state; any output not listed for a state is 0.
REQ-017 FETCH: Mem_read, IRwrite, ldPCreg, PC_write=1; ALUsrcB=01; ALUoperation=ALU_ADD. Next state is DECODE.
REQ-018 DECODE: PCreg=1, ALUsrcB=11, ALUoperation=ALU_ADD, which precomputes the branch target into ALU_out. If the condition fails: instr_done=1 and next state is FETCH. Otherwise next state by type: DP->DP_EXEC, transfer->MEM_ADDR, B->BR, BL->BL_LINK.
REQ-019 DP_EXEC: ALUsrcA=1; ALUsrcB=10 if IR[25]=1, else 00; ALUoperation=IR[24:21]. If opcode=CMP_OP: instr_done=1 and next state is FETCH. Otherwise next state is DP_WB.
REQ-020 DP_WB: reg_write=1, writeMux=01, instr_done=1. Next state is FETCH.
REQ-021 MEM_ADDR: ALUsrcA=1, ALUsrcB=10, ALUoperation=ALU_ADD. Next state is MEM_RD if L=1, else MEM_ST.
REQ-022 MEM_RD: IoD=1, Mem_read=1. Next state is MEM_WB.
REQ-023 MEM_WB: reg_write=1, writeMux=00, instr_done=1. Next state is FETCH.
REQ-024 MEM_ST: IoD=1, Mem_write=1, DT_store=1, instr_done=1. Next state is FETCH.
REQ-025 BL_LINK: reg_write=1, WAddr=1, writeMux=10. Next state is BR.
REQ-026 BR: Jump=1, PCsrc=1, instr_done=1. Next state is FETCH.
REQ-027 Latency in cycles: skipped 2, CMP 3, DP 4, B 3, BL 4, store 4, load 5.
REQ-028 Flags latched by an instruction are visible to the condition check of the immediately following instruction.
REQ-029 Unused state encodings recover to FETCH on the next clock, with all outputs 0 in that cycle.

Reset
REQ-030 While reset=1, every output is forced to 0, regardless of state.
REQ-031 A rising edge with reset=1 sets state=FETCH and Z_f=lt_f=gt_f=0, including mid-instruction; no write strobe reaches the datapath during the reset cycle.
REQ-032 In the first cycle after reset deasserts, the FETCH outputs of REQ-017 are asserted.

Verification
REQ-033 Reset, then IR_O=0xE0800000 (AL, DP ADD, register operand) -> FETCH, DECODE, DP_EXEC (ALUoperation=4'b0100, ALUsrcB=00), DP_WB (reg_write=1, writeMux=01); instr_done pulses once, in cycle 4.
REQ-034 CMP with S=1 and Z=1 in DP_EXEC, then BEQ IR_O=0x08000005 -> reg_write stays 0 for the CMP; BR follows with Jump=1, PCsrc=1.
REQ-035 BNE while Z_f=1 -> instr_done=1 in DECODE; returns to FETCH after 2 cycles; Jump never asserted.
REQ-036 Load IR_O=0xE4100004 -> 5-cycle sequence; MEM_RD has IoD=1, Mem_read=1; MEM_WB has writeMux=00. Store with L=0 -> MEM_ST has Mem_write=1, DT_store=1.
REQ-037 BL IR_O=0xEC000010 -> BL_LINK (WAddr=1, writeMux=10, reg_write=1), then BR (Jump=1).
REQ-038 reset asserted during MEM_RD -> all outputs are 0 that cycle; FETCH follows; flags read 0, so EQ fails.
